// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants for the IF/MEM memory arbiter
// Holds the FSM state encoding, the owner constants used when granting the
// bus, and the default address/data widths.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY_I = 2'b01;
    localparam logic [1:0] BUSY_D = 2'b10;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - single-ported memory bus between arbiter and memory
// Ports (master = arbiter, slave = memory):
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : transaction, master -> slave
//   mem_rdata/mem_ack                        : completion, slave -> master
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority arbiter sharing one memory between IF and MEM ports
// Ports:
//   clk_i, rst_i             : clock, asynchronous active-high reset
//   if_req_i/if_addr_i       : fetch request, held until if_ready_o
//   if_flush_i               : kills the in-flight fetch (data discarded)
//   if_rdata_o/if_ready_o    : fetched word and one-cycle completion pulse
//   if_stall_o               : if_req_i & ~if_ready_o
//   d_req_i/d_we_i/d_addr_i/d_wdata_i/d_be_i : data request, held until d_ready_o
//   d_rdata_o/d_ready_o      : load data and one-cycle completion pulse
//   d_stall_o                : d_req_i & ~d_ready_o
//   bus                      : memory bus (master side)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_ready_o,
    output logic                if_stall_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_ready_o,
    output logic                d_stall_o,
    mem_arbiter_if.master       bus
);

    localparam int BE_W = DATA_W / 8;

    logic [1:0]        state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q,    mem_be_d;
    logic              if_ready_q,  if_ready_d;
    logic              d_ready_q,   d_ready_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              discard_q,   discard_d;

    logic if_elig;
    logic d_elig;
    logic grant_own;

    // A port whose ready is high this cycle still shows its old request;
    // masking it keeps the completed access from being issued twice.
    assign if_elig   = if_req_i & ~if_ready_q;
    assign d_elig    = d_req_i  & ~d_ready_q;
    assign grant_own = d_elig ? OWN_D : OWN_IF;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        discard_d   = discard_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_elig || if_elig) begin
                    mem_req_d = 1'b1;
                    if (grant_own == OWN_D) begin
                        state_d     = BUSY_D;
                        mem_we_d    = d_we_i;
                        mem_addr_d  = d_addr_i;
                        mem_wdata_d = d_wdata_i;
                        mem_be_d    = d_be_i;
                    end else begin
                        state_d     = BUSY_I;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                        // A flush in the grant cycle already targets this fetch.
                        discard_d   = if_flush_i;
                    end
                end
            end
            BUSY_I: begin
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    // A flush arriving together with the ack still kills the data.
                    if (!(discard_q || if_flush_i)) begin
                        if_rdata_d = bus.mem_rdata;
                        if_ready_d = 1'b1;
                    end
                end else if (if_flush_i) begin
                    discard_d = 1'b1;
                end
            end
            BUSY_D: begin
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    d_rdata_d = bus.mem_rdata;
                    d_ready_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                discard_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            discard_q   <= discard_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;

    assign if_rdata_o = if_rdata_q;
    assign if_ready_o = if_ready_q;
    assign d_rdata_o  = d_rdata_q;
    assign d_ready_o  = d_ready_q;
    assign if_stall_o = if_req_i & ~if_ready_q;
    assign d_stall_o  = d_req_i  & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_stall;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_flush_i (if_flush),
        .if_rdata_o (if_rdata),
        .if_ready_o (if_ready),
        .if_stall_o (if_stall),
        .d_req_i    (d_req),
        .d_we_i     (d_we),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_be_i     (d_be),
        .d_rdata_o  (d_rdata),
        .d_ready_o  (d_ready),
        .d_stall_o  (d_stall),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory model: acks in the k-th cycle of mem_req, merges stores by byte.
    logic [31:0] mem [0:1023];
    int          k_cfg = 1;
    int          mcnt  = 0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | (i << 2);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!bus.mem_req) begin
                mcnt = 0;
                bus.mem_ack = 1'b0;
            end else if (bus.mem_ack) begin
                mcnt = 0;
                bus.mem_ack = 1'b0;
            end else begin
                mcnt++;
                if (mcnt >= k_cfg) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr[11:2]];
                    if (bus.mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.mem_be[b]) mem[bus.mem_addr[11:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Event log for the multi-cycle sequences.
    logic [31:0] iss_n[$], iss_addr[$], iss_we[$], iss_be[$];
    logic [31:0] ifr_n[$], ifr_d[$], dr_n[$];
    int          cyc;
    bit          prev_req;

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    task automatic clear_log();
        iss_n.delete(); iss_addr.delete(); iss_we.delete(); iss_be.delete();
        ifr_n.delete(); ifr_d.delete(); dr_n.delete();
        cyc = 0;
        prev_req = bus.mem_req;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.mem_req && !prev_req) begin
            iss_n.push_back(32'(cyc));
            iss_addr.push_back(bus.mem_addr);
            iss_we.push_back({31'b0, bus.mem_we});
            iss_be.push_back({28'b0, bus.mem_be});
        end
        prev_req = bus.mem_req;
        if (if_ready) begin
            ifr_n.push_back(32'(cyc));
            ifr_d.push_back(if_rdata);
        end
        if (d_ready) dr_n.push_back(32'(cyc));
    endtask

    typedef struct {
        bit          is_if;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          k;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
        int          exp_rdy;
    } vec_t;

    vec_t tv[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          rdy_n;
        int          req_n;
        bit          moved;
        bit          stall_at_rdy;
        logic [31:0] a0, wd0, rd;
        logic        we0;
        logic [3:0]  be0;

        tv[0] = '{0, 0, 32'h100, 32'h0,         4'hF, 2, 4'hF, 32'hC0DE0100, 3};
        tv[1] = '{0, 1, 32'h200, 32'h11223344,  4'h3, 1, 4'h3, 32'h0,        2};
        tv[2] = '{0, 0, 32'h200, 32'h0,         4'hF, 3, 4'hF, 32'hC0DE3344, 4};
        tv[3] = '{1, 0, 32'h040, 32'h0,         4'h5, 1, 4'hF, 32'hC0DE0040, 2};
        tv[4] = '{1, 0, 32'h080, 32'h0,         4'h5, 4, 4'hF, 32'hC0DE0080, 5};
        tv[5] = '{0, 1, 32'h300, 32'hAABBCCDD,  4'hC, 2, 4'hC, 32'h0,        3};
        tv[6] = '{0, 0, 32'h300, 32'h0,         4'hF, 1, 4'hF, 32'hAABB0300, 2};

        rst = 1'b1;
        if_req = 0; if_addr = 0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req",  {31'b0, bus.mem_req}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_be",   {28'b0, bus.mem_be}, 32'h0);
        chk("rst_ready",    {30'b0, if_ready, d_ready}, 32'h0);
        chk("rst_rdata",    if_rdata | d_rdata, 32'h0);
        rst = 1'b0;

        // Isolated single accesses.
        for (int i = 0; i < 7; i++) begin
            k_cfg = tv[i].k;
            repeat (2) @(negedge clk);
            if (tv[i].is_if) begin
                if_req = 1; if_addr = tv[i].addr; d_be = tv[i].be;
            end else begin
                d_req = 1; d_we = tv[i].we; d_addr = tv[i].addr;
                d_wdata = tv[i].wdata; d_be = tv[i].be;
            end
            #1;
            chk($sformatf("v%0d_stall_req", i), {31'b0, tv[i].is_if ? if_stall : d_stall}, 32'h1);
            req_n = -1; rdy_n = -1; moved = 0; stall_at_rdy = 1;
            a0 = 0; wd0 = 0; we0 = 0; be0 = 0; rd = 0;
            for (n = 1; n <= 40; n++) begin
                @(negedge clk);
                if (bus.mem_req && req_n < 0) begin
                    req_n = n; a0 = bus.mem_addr; we0 = bus.mem_we;
                    be0 = bus.mem_be; wd0 = bus.mem_wdata;
                end else if (bus.mem_req && (bus.mem_addr !== a0 || bus.mem_be !== be0 || bus.mem_we !== we0)) begin
                    moved = 1;
                end
                if (tv[i].is_if ? if_ready : d_ready) begin
                    rdy_n = n;
                    rd = tv[i].is_if ? if_rdata : d_rdata;
                    stall_at_rdy = tv[i].is_if ? if_stall : d_stall;
                    chk($sformatf("v%0d_req_at_rdy", i), {31'b0, bus.mem_req}, 32'h0);
                    break;
                end
            end
            if_req = 0; d_req = 0;
            chk($sformatf("v%0d_req_lat", i), 32'(req_n), 32'd1);
            chk($sformatf("v%0d_rdy_lat", i), 32'(rdy_n), 32'(tv[i].exp_rdy));
            chk($sformatf("v%0d_addr", i), a0, tv[i].addr);
            chk($sformatf("v%0d_we", i), {31'b0, we0}, {31'b0, tv[i].we});
            chk($sformatf("v%0d_be", i), {28'b0, be0}, {28'b0, tv[i].exp_be});
            chk($sformatf("v%0d_stable", i), {31'b0, moved}, 32'h0);
            chk($sformatf("v%0d_stall_rdy", i), {31'b0, stall_at_rdy}, 32'h0);
            if (tv[i].we) chk($sformatf("v%0d_wdata", i), wd0, tv[i].wdata);
            else          chk($sformatf("v%0d_rdata", i), rd, tv[i].exp_rdata);
        end

        // Contention: store wins, fetch issued the cycle after d_ready.
        k_cfg = 2;
        repeat (2) @(negedge clk);
        clear_log();
        if_req = 1; if_addr = 32'h40;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h55667788; d_be = 4'h3;
        #1;
        chk("ct_if_stall", {31'b0, if_stall}, 32'h1);
        repeat (8) begin
            step();
            if (d_ready) d_req = 0;
            if (if_ready) if_req = 0;
        end
        chk("ct_iss_cnt", 32'(iss_n.size()), 32'd2);
        chk("ct_iss0_n", qat(iss_n, 0), 32'd1);
        chk("ct_iss0_addr", qat(iss_addr, 0), 32'h200);
        chk("ct_iss0_we", qat(iss_we, 0), 32'h1);
        chk("ct_iss0_be", qat(iss_be, 0), 32'h3);
        chk("ct_dr_n", qat(dr_n, 0), 32'd3);
        chk("ct_iss1_n", qat(iss_n, 1), 32'd4);
        chk("ct_iss1_addr", qat(iss_addr, 1), 32'h40);
        chk("ct_iss1_be", qat(iss_be, 1), 32'hF);
        chk("ct_ifr_n", qat(ifr_n, 0), 32'd6);
        chk("ct_ifr_d", qat(ifr_d, 0), 32'hC0DE0040);

        // Flush while the fetch is in flight.
        k_cfg = 3;
        repeat (2) @(negedge clk);
        clear_log();
        if_req = 1; if_addr = 32'h40;
        step();
        if_flush = 1; if_addr = 32'h80;
        step();
        if_flush = 0;
        repeat (8) begin
            step();
            if (if_ready) if_req = 0;
        end
        chk("fl_iss_cnt", 32'(iss_n.size()), 32'd2);
        chk("fl_iss1_n", qat(iss_n, 1), 32'd5);
        chk("fl_iss1_addr", qat(iss_addr, 1), 32'h80);
        chk("fl_ifr_cnt", 32'(ifr_n.size()), 32'd1);
        chk("fl_ifr_n", qat(ifr_n, 0), 32'd8);
        chk("fl_ifr_d", qat(ifr_d, 0), 32'hC0DE0080);

        // Flush in the same cycle as mem_ack.
        k_cfg = 2;
        repeat (2) @(negedge clk);
        clear_log();
        if_req = 1; if_addr = 32'h40;
        step();
        step();
        if_flush = 1; if_addr = 32'h80;
        step();
        if_flush = 0;
        repeat (6) begin
            step();
            if (if_ready) if_req = 0;
        end
        chk("fa_iss_cnt", 32'(iss_n.size()), 32'd2);
        chk("fa_iss1_n", qat(iss_n, 1), 32'd4);
        chk("fa_iss1_addr", qat(iss_addr, 1), 32'h80);
        chk("fa_ifr_cnt", 32'(ifr_n.size()), 32'd1);
        chk("fa_ifr_n", qat(ifr_n, 0), 32'd6);
        chk("fa_ifr_d", qat(ifr_d, 0), 32'hC0DE0080);

        // Flush in the IDLE cycle that grants the fetch.
        k_cfg = 1;
        repeat (2) @(negedge clk);
        clear_log();
        if_req = 1; if_addr = 32'h40; if_flush = 1;
        step();
        if_flush = 0; if_addr = 32'hC0;
        repeat (6) begin
            step();
            if (if_ready) if_req = 0;
        end
        chk("fg_iss_cnt", 32'(iss_n.size()), 32'd2);
        chk("fg_iss0_addr", qat(iss_addr, 0), 32'h40);
        chk("fg_iss1_n", qat(iss_n, 1), 32'd3);
        chk("fg_ifr_cnt", 32'(ifr_n.size()), 32'd1);
        chk("fg_ifr_n", qat(ifr_n, 0), 32'd4);
        chk("fg_ifr_d", qat(ifr_d, 0), 32'hC0DE00C0);

        // Back-to-back fetches at k=1, request held through the ready cycle.
        k_cfg = 1;
        repeat (2) @(negedge clk);
        clear_log();
        if_req = 1; if_addr = 32'h40;
        repeat (10) begin
            step();
            if (if_ready) begin
                if_addr = if_addr + 32'd4;
                if (ifr_n.size() == 3) if_req = 0;
            end
        end
        chk("bb_iss_cnt", 32'(iss_n.size()), 32'd3);
        chk("bb_iss1_n", qat(iss_n, 1), 32'd4);
        chk("bb_iss2_n", qat(iss_n, 2), 32'd7);
        chk("bb_iss2_addr", qat(iss_addr, 2), 32'h48);
        chk("bb_ifr0_n", qat(ifr_n, 0), 32'd2);
        chk("bb_ifr2_n", qat(ifr_n, 2), 32'd8);
        chk("bb_ifr1_d", qat(ifr_d, 1), 32'hC0DE0044);

        // Reset during a long data access.
        k_cfg = 5;
        repeat (2) @(negedge clk);
        clear_log();
        d_req = 1; d_we = 0; d_addr = 32'h100; d_be = 4'hF;
        step();
        step();
        chk("rs_busy_req", {31'b0, bus.mem_req}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rs_mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("rs_mem_addr", bus.mem_addr, 32'h0);
        chk("rs_mem_be", {28'b0, bus.mem_be}, 32'h0);
        chk("rs_rdata", if_rdata | d_rdata, 32'h0);
        d_req = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
        repeat (10) step();
        chk("rs_no_dready", 32'(dr_n.size()), 32'd0);
        chk("rs_no_issue", 32'(iss_n.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, variable-latency memory between the instruction-fetch (IF) port and the data (MEM-stage) port of the 5-stage pipeline. It sequences one memory transaction at a time and gives data accesses fixed priority over fetches. It returns per-port ready pulses and stall levels that feed the pipeline's stall logic. Fetches that are in flight when a control-flow flush arrives are completed on the bus, and their data is discarded.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables = DATA_W/8)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_flush  in  1  pulse from pipeline control (flowChange); kills in-flight fetch
- if_rdata  out  DATA_W  fetched word; valid when if_ready
- if_ready  out  1  one-cycle completion pulse
- if_stall  out  1  if_req & ~if_ready
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_rdata  out  DATA_W  load data; valid when d_ready
- d_ready  out  1  one-cycle completion pulse
- d_stall  out  1  d_req & ~d_ready
- mem_req  out  1  bus request; held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_be  out  —  latched transaction fields
- mem_rdata  in  DATA_W  valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion from memory

## Operation
- FSM states and transitions:
  - IDLE: if d_req is eligible → BUSY_D; else if if_req is eligible → BUSY_I; else stay.
  - BUSY_I: on mem_ack → IDLE.
  - BUSY_D: on mem_ack → IDLE.
- Eligibility: a port's req is ignored in the cycle its own ready is high. This prevents re-issuing a just-completed request.
- On leaving IDLE, the winner's addr, we, wdata and be are latched into mem_* registers. Fetches drive mem_we=0 and mem_be all-ones.
- mem_* fields stay stable for the whole BUSY state.
- On mem_ack in BUSY_D: d_rdata ← mem_rdata, and d_ready=1 the next cycle. Stores also pulse d_ready; d_rdata is don't-care for stores.
- On mem_ack in BUSY_I: if the discard flag is clear, if_rdata ← mem_rdata and if_ready=1 the next cycle. If the discard flag is set, no if_ready is produced, and the flag is cleared.
- Discard flag rules:
  - Set by if_flush while in BUSY_I, including in the cycle mem_ack arrives.
  - Also set by if_flush in the IDLE cycle that grants a fetch.
  - Ignored otherwise.
- A flushed fetch still holds the bus until mem_ack. The refetch then re-arbitrates from IDLE with the new if_addr.
- Data requests cannot be flushed.
- if_stall and d_stall are combinational from req and the registered ready.

## Timing
- Reset values:
  - state = IDLE
  - mem_req = mem_we = 0
  - mem_addr = mem_wdata = mem_be = 0
  - if_ready = d_ready = 0
  - if_rdata = d_rdata = 0
  - discard flag = 0
- Reset asserted mid-transaction: the transaction is abandoned, mem_req drops asynchronously, and no ready pulse is produced.
- Request sampled at edge t: mem_req=1 from t+1.
- mem_ack at cycle t+k (k≥1): ready=1 and mem_req=0 in cycle t+k+1; the FSM is in IDLE in that cycle.
- Minimum turnaround is 3 cycles per access at k=1.
- Back-to-back accesses on one port: the next issue is no earlier than t+k+2.
- Other port pending at completion: it is granted in the ready cycle and issues one cycle later.
- Both ports request in IDLE: data wins; the fetch waits. There is no starvation counter, because a stalled MEM stage also stalls IF.
- mem_ack while IDLE is ignored. mem_ack is never generated by memory without mem_req.

## Structure
- Shared package mem_arb_pkg:
  - State encoding: IDLE=2'b00, BUSY_I=2'b01, BUSY_D=2'b10.
  - Owner constants OWN_IF and OWN_D.
  - Default widths.
- Single module; no sub-module is warranted. The FSM, latch registers and discard flag together are about 200 lines.

## Test plan
- Load only, memory k=2: d_req addr 0x100 → mem_req 1 from t+1; d_ready at t+3 with d_rdata = memory word; d_stall high from t to t+2.
- Contention: if_req (0x40) and d_req (0x200, we=1, be=4'b0011) in the same IDLE cycle → store issued first with mem_be=0011. Fetch issued in the cycle after d_ready; if_ready follows the fetch ack.
- Flush in flight: fetch 0x40 in BUSY_I, if_flush pulse, if_addr changes to 0x80 → no if_ready for 0x40; the next mem_addr is 0x80 after ack.
- Flush coincident with mem_ack in BUSY_I → data discarded, no if_ready; FSM returns to IDLE normally.
- Reset mid-transaction: reset asserted during BUSY_D with k=5 → mem_req=0 immediately; all outputs at reset values; no d_ready after release.
- Back-to-back fetches, k=1 → one fetch every 3 cycles; req held high through the ready cycle is not re-issued.
